scoreboard_regfile: RTL and testbench

Parametrised register file with an integrated per-register in-flight-write scoreboard. It replaces the fixed 2-read/1-write register file and the load-use-only hazard check in the pipelined core. The ID stage reads up to NUM_RD sources and sees whether each one is still awaiting a writeback. Issue marks a destination as pending, and the WB stage retires it. This lets deeper or multi-cycle EX/MEM stages stall correctly without the pipeline walking register tags.

---
 rtl/scoreboard_regfile.sv | 98 +++++++++
 tb/tb_scoreboard_regfile.sv | 138 +++++++++++++
 2 files changed

// File: rtl/scoreboard_regfile.sv
// Register file with per-register in-flight write counters for ID-stage hazard detection.
// Reads are zero-latency with writeback bypass; issue/retire update counters at the next edge; issue_full_o must gate issue.
module scoreboard_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int CNT_W  = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_pend_o,
    input  logic                     issue_i,
    input  logic [ADDR_W-1:0]        issue_dst_i,
    output logic                     issue_full_o,
    input  logic                     wb_en_i,
    input  logic                     wb_kill_i,
    input  logic [ADDR_W-1:0]        wb_addr_i,
    input  logic [DATA_W-1:0]        wb_data_i,
    output logic                     busy_o,
    output logic                     err_o
);
    localparam int NREG = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] regs [NREG];
    logic [CNT_W-1:0]  cnt  [NREG];

    logic            wb_write;
    logic            wb_retire;
    logic            issue_ok;
    logic [NREG-1:0] inc_vec;
    logic [NREG-1:0] dec_vec;

    assign wb_write     = wb_en_i && !wb_kill_i && (wb_addr_i != '0);
    assign wb_retire    = wb_en_i && (cnt[wb_addr_i] != '0);
    assign issue_full_o = (cnt[issue_dst_i] == CNT_MAX) && !(wb_en_i && (wb_addr_i == issue_dst_i));
    assign issue_ok     = issue_i && !issue_full_o;
    assign inc_vec      = issue_ok  ? (NREG'(1) << issue_dst_i) : '0;
    assign dec_vec      = wb_retire ? (NREG'(1) << wb_addr_i)   : '0;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              retire_hit;
        assign addr       = rd_addr_i[k*ADDR_W +: ADDR_W];
        assign retire_hit = wb_en_i && (wb_addr_i == addr) && (cnt[addr] != '0);
        // A same-cycle issue is deliberately not counted, so an instruction never stalls on itself.
        assign rd_pend_o[k] = (cnt[addr] - CNT_W'(retire_hit)) != '0;
        assign rd_data_o[k*DATA_W +: DATA_W] =
            (wb_write && (wb_addr_i == addr)) ? wb_data_i :
            (addr == '0)                      ? '0        : regs[addr];
    end

    always_comb begin
        busy_o = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            busy_o = busy_o || (cnt[ADDR_W'(r)] != '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[ADDR_W'(r)] <= '0;
            end
        end else begin
            // Register 0 is never touched, so its counter stays at its reset value.
            for (int r = 1; r < NREG; r++) begin
                case ({inc_vec[ADDR_W'(r)], dec_vec[ADDR_W'(r)]})
                    2'b10:   cnt[ADDR_W'(r)] <= cnt[ADDR_W'(r)] + 1'b1;
                    2'b01:   cnt[ADDR_W'(r)] <= cnt[ADDR_W'(r)] - 1'b1;
                    default: cnt[ADDR_W'(r)] <= cnt[ADDR_W'(r)];
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREG; r++) begin
                regs[ADDR_W'(r)] <= '0;
            end
        end else if (wb_write) begin
            regs[wb_addr_i] <= wb_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if ((issue_i && issue_full_o) ||
                     (wb_en_i && (wb_addr_i != '0) && (cnt[wb_addr_i] == '0)) ||
                     (wb_kill_i && !wb_en_i)) begin
            err_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_scoreboard_regfile.sv
// Directed bench for scoreboard_regfile: expected outputs queued per cycle, popped and compared mid-cycle.
module tb_scoreboard_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_pend;
    logic        issue;
    logic [4:0]  issue_dst;
    logic        issue_full;
    logic        wb_en;
    logic        wb_kill;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  pend;
        logic        busy;
        logic        full;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    scoreboard_regfile #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .CNT_W(2)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .rd_pend_o    (rd_pend),
        .issue_i      (issue),
        .issue_dst_i  (issue_dst),
        .issue_full_o (issue_full),
        .wb_en_i      (wb_en),
        .wb_kill_i    (wb_kill),
        .wb_addr_i    (wb_addr),
        .wb_data_i    (wb_data),
        .busy_o       (busy),
        .err_o        (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expected outputs, compare at the falling edge, then advance.
    task automatic cyc(input string tag,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic iss, input logic [4:0] dst,
                       input logic wen, input logic kill, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [31:0] e_d0, input logic [31:0] e_d1, input logic [1:0] e_pend,
                       input logic e_busy, input logic e_full, input logic e_err);
        exp_t e;
        rd_addr   = {a1, a0};
        issue     = iss;
        issue_dst = dst;
        wb_en     = wen;
        wb_kill   = kill;
        wb_addr   = wa;
        wb_data   = wd;
        e.tag = tag; e.d0 = e_d0; e.d1 = e_d1; e.pend = e_pend;
        e.busy = e_busy; e.full = e_full; e.err = e_err;
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        check({e.tag, ".d0"},   rd_data[31:0],  e.d0);
        check({e.tag, ".d1"},   rd_data[63:32], e.d1);
        check({e.tag, ".pend"}, {30'd0, rd_pend}, {30'd0, e.pend});
        check({e.tag, ".busy"}, {31'd0, busy},  {31'd0, e.busy});
        check({e.tag, ".full"}, {31'd0, issue_full}, {31'd0, e.full});
        check({e.tag, ".err"},  {31'd0, err},   {31'd0, e.err});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rd_addr = '0; issue = 1'b0; issue_dst = '0;
        wb_en = 1'b0; wb_kill = 1'b0; wb_addr = '0; wb_data = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        //    tag        a0  a1  iss dst wen kil wa  wd            d0            d1  pend  bsy ful err
        cyc("rst_rd",     5,  0, 0,  0,  0,  0,  0, 32'h0,        32'h0,        0, 2'b00, 0, 0, 0);
        cyc("iss3",       3,  3, 1,  3,  0,  0,  0, 32'h0,        32'h0,        0, 2'b00, 0, 0, 0);
        cyc("pend3",      3,  3, 0,  0,  0,  0,  0, 32'h0,        32'h0,        0, 2'b11, 1, 0, 0);
        cyc("wb3_byp",    3,  0, 0,  0,  1,  0,  3, 32'hDEADBEEF, 32'hDEADBEEF, 0, 2'b00, 1, 0, 0);
        cyc("rd3",        3,  3, 0,  0,  0,  0,  0, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0, 0, 0);

        cyc("iss7_a",     7,  0, 1,  7,  0,  0,  0, 32'h0,        32'h0,        0, 2'b00, 0, 0, 0);
        cyc("iss7_b",     7,  0, 1,  7,  0,  0,  0, 32'h0,        32'h0,        0, 2'b01, 1, 0, 0);
        cyc("iss7_c",     7,  0, 1,  7,  0,  0,  0, 32'h0,        32'h0,        0, 2'b01, 1, 0, 0);
        cyc("iss7_over",  7,  0, 1,  7,  0,  0,  0, 32'h0,        32'h0,        0, 2'b01, 1, 1, 0);
        cyc("full7",      7,  0, 0,  7,  0,  0,  0, 32'h0,        32'h0,        0, 2'b01, 1, 1, 1);
        cyc("ret7_a",     7,  0, 0,  7,  1,  0,  7, 32'h77,       32'h77,       0, 2'b01, 1, 0, 1);
        cyc("ret7_b",     7,  0, 0,  7,  1,  0,  7, 32'h77,       32'h77,       0, 2'b01, 1, 0, 1);
        cyc("ret7_c",     7,  0, 0,  7,  1,  0,  7, 32'h77,       32'h77,       0, 2'b00, 1, 0, 1);
        cyc("idle7",      7,  0, 0,  7,  0,  0,  0, 32'h0,        32'h77,       0, 2'b00, 0, 0, 1);

        cyc("iss4",       4,  0, 1,  4,  0,  0,  0, 32'h0,        32'h0,        0, 2'b00, 0, 0, 1);
        cyc("iss_ret4",   4,  0, 1,  4,  1,  0,  4, 32'h44,       32'h44,       0, 2'b00, 1, 0, 1);
        cyc("pend4",      4,  0, 0,  0,  0,  0,  0, 32'h0,        32'h44,       0, 2'b01, 1, 0, 1);
        cyc("ret4",       4,  0, 0,  0,  1,  0,  4, 32'h45,       32'h45,       0, 2'b00, 1, 0, 1);
        cyc("idle4",      4,  0, 0,  0,  0,  0,  0, 32'h0,        32'h45,       0, 2'b00, 0, 0, 1);

        cyc("iss9_wr",    9,  0, 1,  9,  1,  0,  9, 32'h11,       32'h11,       0, 2'b00, 0, 0, 1);
        cyc("kill9",      9,  9, 0,  0,  1,  1,  9, 32'h99,       32'h11,       32'h11, 2'b00, 1, 0, 1);
        cyc("rd9",        9,  0, 0,  0,  0,  0,  0, 32'h0,        32'h11,       0, 2'b00, 0, 0, 1);
        cyc("wb_r0",      0,  0, 0,  0,  1,  0,  0, 32'hFFFF,     32'h0,        0, 2'b00, 0, 0, 1);
        cyc("rd_r0",      0,  0, 0,  0,  0,  0,  0, 32'h0,        32'h0,        0, 2'b00, 0, 0, 1);

        cyc("iss2_a",     2,  0, 1,  2,  0,  0,  0, 32'h0,        32'h0,        0, 2'b00, 0, 0, 1);
        cyc("iss2_b",     2,  0, 1,  2,  0,  0,  0, 32'h0,        32'h0,        0, 2'b01, 1, 0, 1);
        rst = 1'b1;
        cyc("rst_wb2",    2,  0, 0,  0,  1,  0,  2, 32'h22,       32'h22,       0, 2'b01, 1, 0, 1);
        rst = 1'b0;
        cyc("post_rst",   2,  0, 0,  2,  0,  0,  0, 32'h0,        32'h0,        0, 2'b00, 0, 0, 0);
        cyc("kill_noen",  0,  0, 0,  0,  0,  1,  0, 32'h0,        32'h0,        0, 2'b00, 0, 0, 0);
        cyc("err_kill",   0,  0, 0,  0,  0,  0,  0, 32'h0,        32'h0,        0, 2'b00, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
